// File: rtl/decimator_channel_arbiter.sv
// Round-robin arbiter sharing one downstream sample bus among NumChannels
// decimator output streams. Each stream uses a valid/ready handshake; the
// granted word is captured in a single output register tagged with its
// source channel.
//
// Ports:
//   i_clk           clock, all logic on posedge
//   i_rst_n         asynchronous reset, active-low
//   i_in            packed channel data, channel k at [k*WordLengthBits +: WordLengthBits]
//   i_in_valid      per-channel word available
//   o_in_ready      per-channel accept, one-hot or zero
//   o_out           registered output word
//   o_out_channel   source channel of o_out
//   o_out_valid     o_out/o_out_channel hold a word
//   i_out_ready     downstream accepts the word this cycle
module decimator_channel_arbiter #(
  parameter int unsigned WordLengthBits = 12,
  parameter int unsigned NumChannels    = 4,
  localparam int unsigned ChannelIdBits = $clog2(NumChannels)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [NumChannels*WordLengthBits-1:0] i_in,
  input  logic [NumChannels-1:0]                i_in_valid,
  output logic [NumChannels-1:0]                o_in_ready,
  output logic [WordLengthBits-1:0]             o_out,
  output logic [ChannelIdBits-1:0]              o_out_channel,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready
);

  localparam logic [ChannelIdBits-1:0] LastCh = ChannelIdBits'(NumChannels - 1);

  logic [ChannelIdBits-1:0]  r_ptr;
  logic [WordLengthBits-1:0] r_out;
  logic [ChannelIdBits-1:0]  r_out_channel;
  logic                      r_out_valid;

  logic                      w_found;
  logic [ChannelIdBits-1:0]  w_grant;
  logic                      w_load;
  logic [WordLengthBits-1:0] w_data;
  logic [ChannelIdBits-1:0]  w_ptr_next;

  // Search ptr, ptr+1, ... modulo NumChannels; first requester wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int unsigned off = 0; off < NumChannels; off++) begin
      logic [ChannelIdBits-1:0] idx;
      idx = ChannelIdBits'((32'(r_ptr) + off) % NumChannels);
      if (!w_found && i_in_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  // Reset is folded in so no source is acknowledged while held in reset.
  assign w_load = i_rst_n && w_found && (!r_out_valid || i_out_ready);

  always_comb begin
    w_data     = '0;
    o_in_ready = '0;
    for (int unsigned k = 0; k < NumChannels; k++) begin
      if (w_grant == ChannelIdBits'(k)) begin
        w_data        = i_in[k*WordLengthBits +: WordLengthBits];
        o_in_ready[k] = w_load;
      end
    end
  end

  assign w_ptr_next = (w_grant == LastCh) ? '0 : w_grant + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr         <= '0;
      r_out         <= '0;
      r_out_channel <= '0;
      r_out_valid   <= 1'b0;
    end else if (w_load) begin
      r_ptr         <= w_ptr_next;
      r_out         <= w_data;
      r_out_channel <= w_grant;
      r_out_valid   <= 1'b1;
    end else if (r_out_valid && i_out_ready) begin
      // Drain with nothing to replace it; data/channel keep last value.
      r_out_valid <= 1'b0;
    end
  end

  assign o_out         = r_out;
  assign o_out_channel = r_out_channel;
  assign o_out_valid   = r_out_valid;

endmodule

// File: tb/tb_decimator_channel_arbiter.sv
// Directed bench for decimator_channel_arbiter (4 channels, 12-bit words).
module tb_decimator_channel_arbiter;

  localparam int unsigned W = 12;
  localparam int unsigned N = 4;

  logic          clk;
  logic          rst_n;
  logic [N*W-1:0] in_bus;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out;
  logic [1:0]    out_channel;
  logic          out_valid;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  decimator_channel_arbiter #(
    .WordLengthBits(W),
    .NumChannels   (N)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in         (in_bus),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_out        (out),
    .o_out_channel(out_channel),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input logic [W-1:0] d2, input logic [W-1:0] d3);
    in_bus = {d3, d2, d1, d0};
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    set_data(12'h000, 12'h001, 12'h002, 12'h003);

    // Held in reset with every channel requesting.
    repeat (100) begin
      step();
      check("rst_out", 32'(out), 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h0);
    end
    check("rst_out_channel", 32'(out_channel), 32'h0);

    // Single channel 2.
    rst_n    = 1'b1;
    in_valid = 4'b0100;
    set_data(12'h000, 12'h000, 12'h123, 12'h000);
    #1;
    check("single_in_ready_first", 32'(in_ready), 32'b0100);
    repeat (3) begin
      step();
      check("single_out", 32'(out), 32'h123);
      check("single_chan", 32'(out_channel), 32'd2);
      check("single_valid", 32'(out_valid), 32'h1);
      check("single_in_ready", 32'(in_ready), 32'b0100);
    end

    // Async reset restores ptr=0 before the round-robin run.
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'h0);
    in_valid = 4'hF;
    set_data(12'h000, 12'h001, 12'h002, 12'h003);
    rst_n = 1'b1;
    #1;
    check("rr_in_ready_first", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_chan", 32'(out_channel), 32'(i % 4));
      check("rr_out", 32'(out), 32'(i % 4));
      check("rr_valid", 32'(out_valid), 32'h1);
      check("rr_in_ready", 32'(in_ready), 32'h1 << ((i + 1) % 4));
    end

    // Backpressure: ch0 held, ptr at 1.
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_now", 32'(in_ready), 32'h0);
    repeat (100) begin
      step();
      check("bp_chan", 32'(out_channel), 32'd0);
      check("bp_out", 32'(out), 32'h000);
      check("bp_valid", 32'(out_valid), 32'h1);
      check("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_pulse_in_ready", 32'(in_ready), 32'b0010);
    step();
    out_ready = 1'b0;
    check("bp_after_chan", 32'(out_channel), 32'd1);
    check("bp_after_out", 32'(out), 32'h001);
    check("bp_after_valid", 32'(out_valid), 32'h1);

    // Skip idle: only ch0/ch3; ptr=2 so ch3 goes first.
    in_valid  = 4'b1001;
    set_data(12'h0A5, 12'h001, 12'h002, 12'hF3C);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("skip_chan", 32'(out_channel), (i % 2 == 0) ? 32'd3 : 32'd0);
      check("skip_out", 32'(out), (i % 2 == 0) ? 32'hF3C : 32'h0A5);
      check("skip_valid", 32'(out_valid), 32'h1);
    end

    // No requesters: drain, data/channel keep last value.
    in_valid = 4'b0000;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'h0);
    step();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_out", 32'(out), 32'h0A5);
    check("idle_chan", 32'(out_channel), 32'd0);

    // Reset mid-operation while holding ch1 (ptr=1 after last ch0 grant).
    set_data(12'h000, 12'h001, 12'h002, 12'h003);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    step();
    check("mid_load_chan", 32'(out_channel), 32'd1);
    step();
    check("mid_hold_chan", 32'(out_channel), 32'd1);
    check("mid_hold_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_chan", 32'(out_channel), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    step();
    check("mid_rst_in_ready_edge", 32'(in_ready), 32'h0);
    check("mid_rst_valid_edge", 32'(out_valid), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    step();
    check("post_rst_chan", 32'(out_channel), 32'd0);
    check("post_rst_out", 32'(out), 32'h000);
    check("post_rst_valid", 32'(out_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
